// File: rtl/axi4_lite_mem_sched_pkg.sv
// Response codes, FSM states and arbiter grant sides shared by the
// AXI4-Lite memory scheduler.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_RESP
  } sched_state_t;

  typedef enum logic {
    GRANT_RD,
    GRANT_WR
  } grant_t;

endpackage

// File: rtl/axi4_lite_mem_sched_if.sv
// AXI4-Lite channel bundle between the interconnect (master) and the
// memory scheduler (slave).
interface axi4_lite_mem_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output ARADDR, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY,
    output AWADDR, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID, input  WREADY,
    input  BRESP, BVALID, output BREADY
  );

  modport slave (
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input  RREADY,
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input  BREADY
  );

endinterface

// File: rtl/axi4_lite_mem_sched_chan_hold.sv
// One-entry valid/ready holding register: ready is the registered inverse
// of full, a handshake loads the entry and the consumer clears it on issue.
module axi_chan_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             ready,
  input  logic             clr,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic load;
  logic full_nxt;

  assign load = in_valid && ready;

  // load and clr never coincide: load needs an empty entry, clr a full one
  always_comb begin
    full_nxt = full;
    if (load)
      full_nxt = 1'b1;
    else if (clr)
      full_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      ready <= 1'b0;
    end else begin
      full  <= full_nxt;
      ready <= !full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      data <= in_data;
  end

endmodule

// File: rtl/axi4_lite_mem_sched.sv
// AXI4-Lite slave scheduler: buffers one AR, AW and W beat and sequences
// them round-robin onto a single-port word-addressed memory, one access at a time.
module axi4_lite_mem_sched
  import axi4_lite_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              MEM_AW     = 10,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int              RD_LAT     = 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  axi4_lite_mem_sched_if.slave   axi,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [DATA_W/8-1:0]    mem_wstrb,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 3;

  sched_state_t        state;
  grant_t              last_grant;
  logic [CNT_W-1:0]    rd_cnt;

  logic                ar_full, aw_full, w_full;
  logic [ADDR_W-1:0]   ar_addr, aw_addr;
  logic [DATA_W+STRB_W-1:0] w_bundle;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;

  logic                rd_pend, wr_pend;
  logic                rd_issue, wr_issue;

  logic                rvalid, bvalid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp, bresp;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_LIMIT;
  endfunction

  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a[MEM_AW+1:2];
  endfunction

  axi_chan_hold #(.WIDTH(ADDR_W)) u_ar_hold (
    .clk(ACLK), .rst(ARESET),
    .in_valid(axi.ARVALID), .in_data(axi.ARADDR), .ready(axi.ARREADY),
    .clr(rd_issue), .full(ar_full), .data(ar_addr)
  );

  axi_chan_hold #(.WIDTH(ADDR_W)) u_aw_hold (
    .clk(ACLK), .rst(ARESET),
    .in_valid(axi.AWVALID), .in_data(axi.AWADDR), .ready(axi.AWREADY),
    .clr(wr_issue), .full(aw_full), .data(aw_addr)
  );

  axi_chan_hold #(.WIDTH(DATA_W+STRB_W)) u_w_hold (
    .clk(ACLK), .rst(ARESET),
    .in_valid(axi.WVALID), .in_data({axi.WDATA, axi.WSTRB}), .ready(axi.WREADY),
    .clr(wr_issue), .full(w_full), .data(w_bundle)
  );

  assign {w_data, w_strb} = w_bundle;

  assign rd_pend = ar_full;
  assign wr_pend = aw_full && w_full;

  // Arbiter: a contest goes to the side that did not win the previous contest
  always_comb begin
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    if (state == ST_IDLE) begin
      if (rd_pend && wr_pend) begin
        rd_issue = (last_grant == GRANT_WR);
        wr_issue = (last_grant == GRANT_RD);
      end else begin
        rd_issue = rd_pend;
        wr_issue = wr_pend;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_WR;
      rd_cnt     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      mem_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // last_grant only tracks contested grants
          if (rd_pend && wr_pend)
            last_grant <= rd_issue ? GRANT_RD : GRANT_WR;
          if (rd_issue) begin
            if (in_range(ar_addr)) begin
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(ar_addr);
              rd_cnt   <= '0;
              state    <= ST_RD_WAIT;
            end else begin
              rdata <= '0;
              rresp <= RESP_SLVERR;
              state <= ST_RD_RESP;
            end
          end else if (wr_issue) begin
            if (in_range(aw_addr)) begin
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= word_addr(aw_addr);
              mem_wdata <= w_data;
              mem_wstrb <= w_strb;
              bresp     <= RESP_OKAY;
            end else begin
              bresp <= RESP_SLVERR;
            end
            state <= ST_WR_RESP;
          end
        end
        ST_RD_WAIT: begin
          if (rd_cnt == CNT_W'(RD_LAT)) begin
            rdata  <= mem_rdata;
            rresp  <= RESP_OKAY;
            rvalid <= 1'b1;
            state  <= ST_RD_RESP;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        // Responses entered straight from IDLE raise VALID one cycle after entry
        ST_RD_RESP: begin
          if (!rvalid) begin
            rvalid <= 1'b1;
          end else if (axi.RREADY) begin
            rvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_WR_RESP: begin
          if (!bvalid) begin
            bvalid <= 1'b1;
          end else if (axi.BREADY) begin
            bvalid <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign axi.RVALID = rvalid;
  assign axi.RDATA  = rdata;
  assign axi.RRESP  = rresp;
  assign axi.BVALID = bvalid;
  assign axi.BRESP  = bresp;

endmodule

// File: tb/tb_axi4_lite_mem_sched.sv
// Randomized bench for axi4_lite_mem_sched: transaction-level reference
// memory, response latencies and the memory-port access log are checked.
module tb_axi4_lite_mem_sched;

  localparam int          RD_LAT = 1;
  localparam logic [31:0] LIMIT  = 32'h0000_1000;

  typedef struct {
    int          cyc;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  logic        clk;
  logic        rst;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_en = 1'b0;
  logic        mem_init;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  acc_t        acc_q [$];
  bit          last_wr;

  axi4_lite_mem_sched_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4_lite_mem_sched #(
    .ADDR_W(32), .DATA_W(32), .MEM_AW(10), .ADDR_LIMIT(LIMIT), .RD_LAT(RD_LAT)
  ) dut (
    .ACLK(clk), .ARESET(rst), .axi(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory model: read data is only meaningful RD_LAT (=1) cycle after the strobe
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_wstrb);
    end
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      chk("mem_en_gap", prev_en, 1'b0);
      acc_q.push_back('{cyc, mem_we, mem_addr, mem_wdata, mem_wstrb});
    end
    prev_en = mem_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_access(input bit exp_acc, input int exp_cyc, input logic exp_we,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    chk("acc_count", acc_q.size(), exp_acc ? 1 : 0);
    if (exp_acc && acc_q.size() > 0) begin
      chk("acc_cycle", acc_q[0].cyc, exp_cyc);
      chk("acc_we", acc_q[0].we, exp_we);
      chk("acc_addr", acc_q[0].addr, a[11:2]);
      if (exp_we) begin
        chk("acc_wdata", acc_q[0].wdata, wd);
        chk("acc_wstrb", acc_q[0].wstrb, ws);
      end
    end
    acc_q.delete();
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rr_delay);
    int t, n;
    bit inr;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    inr   = addr < LIMIT;
    exp_d = inr ? ref_mem[addr[11:2]] : 32'h0;
    exp_r = inr ? 2'b00 : 2'b10;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; n = 0;
    while (!bus.ARREADY && n < 20) begin step(); n++; end
    chk("ar_accept", bus.ARREADY, 1'b1);
    t = cyc;
    step();
    bus.ARVALID = 1'b0;
    chk("arready_drop", bus.ARREADY, 1'b0);
    n = 0;
    while (!bus.RVALID && n < 40) begin step(); n++; end
    chk("rvalid_seen", bus.RVALID, 1'b1);
    chk("r_latency", cyc - t, inr ? 3 + RD_LAT : 3);
    chk("rdata", bus.RDATA, exp_d);
    chk("rresp", bus.RRESP, exp_r);
    for (int i = 0; i < rr_delay; i++) begin
      step();
      chk("r_hold", {bus.RVALID, bus.RDATA, bus.RRESP}, {1'b1, exp_d, exp_r});
    end
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    chk("rvalid_drop", bus.RVALID, 1'b0);
    check_access(inr, t + 2, 1'b0, addr, 32'h0, 4'h0);
  endtask

  // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                           input int gap, input int br_delay);
    int aw_start, w_start, t_aw, t_w, t, k, n;
    bit aw_done, w_done, hs_aw, hs_w, inr;
    logic [1:0] exp_r;
    inr = addr < LIMIT;
    exp_r = inr ? 2'b00 : 2'b10;
    aw_start = gap > 0 ? gap : 0;
    w_start  = gap < 0 ? -gap : 0;
    bus.AWADDR = addr; bus.WDATA = wd; bus.WSTRB = ws;
    aw_done = 0; w_done = 0; t_aw = 0; t_w = 0; k = 0;
    while (!(aw_done && w_done) && k < 30) begin
      bus.AWVALID = !aw_done && k >= aw_start;
      bus.WVALID  = !w_done && k >= w_start;
      hs_aw = bus.AWVALID && bus.AWREADY;
      hs_w  = bus.WVALID && bus.WREADY;
      if (hs_aw) t_aw = cyc;
      if (hs_w)  t_w  = cyc;
      step();
      k++;
      if (hs_aw) begin aw_done = 1; chk("awready_drop", bus.AWREADY, 1'b0); end
      if (hs_w)  begin w_done  = 1; chk("wready_drop", bus.WREADY, 1'b0); end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    t = t_aw > t_w ? t_aw : t_w;
    n = 0;
    while (!bus.BVALID && n < 40) begin step(); n++; end
    chk("bvalid_seen", bus.BVALID, 1'b1);
    chk("b_latency", cyc - t, 3);
    chk("bresp", bus.BRESP, exp_r);
    for (int i = 0; i < br_delay; i++) begin
      step();
      chk("b_hold", {bus.BVALID, bus.BRESP}, {1'b1, exp_r});
    end
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
    chk("bvalid_drop", bus.BVALID, 1'b0);
    check_access(inr, t + 2, 1'b1, addr, wd, ws);
    if (inr) ref_mem[addr[11:2]] = merge(ref_mem[addr[11:2]], wd, ws);
  endtask

  // AR and AW/W all accepted on the same edge; the winner alternates per contest
  task automatic contest(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws);
    bit rs, bs, exp_rd_first;
    logic [31:0] rd;
    logic [1:0] br;
    int n;
    exp_rd_first = last_wr;
    bus.ARADDR = ra; bus.AWADDR = wa; bus.WDATA = wd; bus.WSTRB = ws;
    bus.ARVALID = 1'b1; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    chk("contest_ready", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b111);
    step();
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    rs = 0; bs = 0; rd = '0; br = '1; n = 0;
    while (!(rs && bs) && n < 40) begin
      if (bus.RVALID) begin rs = 1; rd = bus.RDATA; end
      if (bus.BVALID) begin bs = 1; br = bus.BRESP; end
      step();
      n++;
    end
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    chk("contest_done", {rs, bs}, 2'b11);
    chk("contest_rdata", rd, ref_mem[ra[11:2]]);
    chk("contest_bresp", br, 2'b00);
    chk("contest_acc_n", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("contest_first_we", acc_q[0].we, !exp_rd_first);
      chk("contest_second_we", acc_q[1].we, exp_rd_first);
    end
    acc_q.delete();
    ref_mem[wa[11:2]] = merge(ref_mem[wa[11:2]], wd, ws);
    last_wr = !exp_rd_first;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_1000;
      1:       return 32'h0000_0FFC;
      2, 3:    return 32'h0000_1000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      default: return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n, hs, g;
    logic [31:0] d, a;
    bit seen;

    rst = 1'b1; mem_init = 1'b1; last_wr = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) step();
    mem_init = 1'b0;

    chk("rst_ready", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b000);
    chk("rst_valid", {bus.RVALID, bus.BVALID}, 2'b00);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, 48'h0);
    chk("rst_resp", {bus.RDATA, bus.RRESP, bus.BRESP}, 36'h0);
    rst = 1'b0;
    chk("ready_at_release", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b000);
    step();
    chk("ready_after_release", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b111);

    axi_read(32'h0000_0010, 0);
    axi_write(32'h0000_0020, 32'h1234_5678, 4'b0101, 3, 0);
    axi_read(32'h0000_0020, 1);
    contest(32'h0000_0004, 32'h0000_0008, 32'hA5A5_0001, 4'b1111);
    contest(32'h0000_0004, 32'h0000_0008, 32'h0BAD_CAFE, 4'b0011);
    axi_read(32'h0000_2000, 0);
    axi_write(32'h0000_2000, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    axi_write(32'h0000_0024, 32'hCAFE_F00D, 4'b0000, -2, 2);

    // Long R stall with a second AR accepted behind it
    bus.ARADDR = 32'h0000_0030; bus.ARVALID = 1'b1;
    chk("stall_ar1_ready", bus.ARREADY, 1'b1);
    step();
    bus.ARVALID = 1'b0; n = 0;
    while (!bus.RVALID && n < 40) begin step(); n++; end
    chk("stall_rvalid", bus.RVALID, 1'b1);
    d = bus.RDATA;
    chk("stall_rdata1", d, ref_mem[12]);
    bus.ARADDR = 32'h0000_0034; bus.ARVALID = 1'b1;
    chk("stall_ar2_ready", bus.ARREADY, 1'b1);
    step();
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold", {bus.RVALID, bus.RDATA, bus.RRESP}, {1'b1, d, 2'b00});
    end
    chk("stall_acc_n", acc_q.size(), 1);
    acc_q.delete();
    hs = cyc;
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 40) begin step(); n++; end
    chk("stall_rdata2", bus.RDATA, ref_mem[13]);
    chk("stall_acc2_n", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("stall_acc2_cyc", acc_q[0].cyc, hs + 2);
    acc_q.delete();
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;

    // Asynchronous reset while a read is waiting on memory data
    bus.ARADDR = 32'h0000_0040; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    step();
    chk("pre_rst_mem_en", mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, 48'h0);
    chk("arst_ready", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b000);
    chk("arst_resp", {bus.RVALID, bus.BVALID, bus.RDATA, bus.RRESP, bus.BRESP}, 38'h0);
    step();
    step();
    rst = 1'b0;
    chk("arst_ready_release", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b000);
    step();
    chk("arst_ready_back", {bus.ARREADY, bus.AWREADY, bus.WREADY}, 3'b111);
    seen = 0;
    bus.RREADY = 1'b1;
    repeat (8) begin
      step();
      if (bus.RVALID || bus.BVALID || mem_en) seen = 1;
    end
    bus.RREADY = 1'b0;
    chk("arst_no_resp", seen, 1'b0);
    acc_q.delete();
    last_wr = 1'b1;
    contest(32'h0000_0044, 32'h0000_0048, 32'h7777_8888, 4'b1100);

    for (int i = 0; i < 60; i++) begin
      a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        axi_read(a, $urandom_range(0, 3));
      end else begin
        g = int'($urandom_range(0, 6)) - 3;
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), g, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
